// File: rtl/grey_fb_pkg.sv
// Shared definitions for the greyscale frame buffer (writer and reader sides).
// A BRAM word packs PIX_PER_WORD 8-bit luma samples; the oldest pixel sits in
// the most significant byte. Pixels are stored in raster order, and a word may
// span the end of a line.
package grey_fb_pkg;

  localparam int H_PIXELS     = 320;
  localparam int V_LINES      = 240;
  localparam int PIX_PER_WORD = 6;
  localparam int PIX_WIDTH    = 8;
  localparam int WORD_WIDTH   = PIX_PER_WORD * PIX_WIDTH;

  // Words needed to hold an h x v frame. The final word may be partly unused.
  function automatic int num_words(input int h, input int v);
    return (h * v + PIX_PER_WORD - 1) / PIX_PER_WORD;
  endfunction

  localparam int NUM_WORDS = num_words(H_PIXELS, V_LINES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } reader_state_t;

endpackage

// File: rtl/grey_word_fifo.sv
// Small synchronous FIFO that holds packed frame words returned by the BRAM.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (empties the FIFO)
//   push, wdata write one word (ignored when full)
//   pop         drop the head word (ignored when empty)
//   rdata       head word, meaningful while !empty
//   empty       no words held
//   count       number of words held (0..DEPTH)
module grey_word_fifo
  import grey_fb_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = WORD_WIDTH,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != CNT_FULL);
    pop_ok   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/grey_frame_reader.sv
// Reads one greyscale frame out of the packed frame BRAM and emits it as a
// raster-ordered stream, one 8-bit luma pixel per transfer.
// Ports:
//   clk_pixel_in, rst_n_in  pixel clock, asynchronous active-low reset
//   start_in                one-cycle pulse, starts a frame when idle
//   addr_out, rd_en_out     BRAM read request (address = word index)
//   rd_data_in              BRAM data, READ_LATENCY cycles after rd_en_out
//   pixel_out, h_out, v_out pixel and its column/row
//   pixel_valid_out         pixel and markers valid
//   pixel_ready_in          downstream accepts
//   sof_out/eol_out/eof_out first pixel / last of line / last of frame
//   busy_out, done_out      frame in progress / one-cycle end pulse
//   state_dbg_out           current FSM state
//
// Stream handshake: a transfer happens on a clock edge where pixel_valid_out
// and pixel_ready_in are both high. While valid is high and ready is low, the
// pixel, coordinates and markers hold their values; valid never drops
// without a transfer.
//
// Fetch uses credits: a read is only issued when the FIFO is guaranteed to
// have a free slot for it on return, counting words still in the BRAM
// pipeline. The FIFO therefore never overflows and the BRAM needs no stall.
module grey_frame_reader
  import grey_fb_pkg::*;
#(
  parameter int H_PIXELS     = grey_fb_pkg::H_PIXELS,
  parameter int V_LINES      = grey_fb_pkg::V_LINES,
  parameter int ADDR_WIDTH   = 17,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  rd_en_out,
  input  logic [WORD_WIDTH-1:0] rd_data_in,
  output logic [7:0]            pixel_out,
  output logic [10:0]           h_out,
  output logic [9:0]            v_out,
  output logic                  pixel_valid_out,
  input  logic                  pixel_ready_in,
  output logic                  sof_out,
  output logic                  eol_out,
  output logic                  eof_out,
  output logic                  busy_out,
  output logic                  done_out,
  output reader_state_t         state_dbg_out
);

  localparam int FIFO_DEPTH  = READ_LATENCY + 1;
  localparam int FRAME_WORDS = num_words(H_PIXELS, V_LINES);
  localparam int CW          = $clog2(FIFO_DEPTH + 1);
  localparam int IW          = $clog2(READ_LATENCY + 1);

  localparam logic [ADDR_WIDTH-1:0] WORDS_A = ADDR_WIDTH'(FRAME_WORDS);
  localparam logic [10:0]           H_LAST  = 11'(H_PIXELS - 1);
  localparam logic [9:0]            V_LAST  = 10'(V_LINES - 1);
  localparam logic [2:0]            LANE_LAST = 3'(PIX_PER_WORD - 1);

  reader_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   issued_q, issued_d;
  logic [READ_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [2:0]              lane_q, lane_d;
  logic [10:0]             h_q, h_d;
  logic [9:0]              v_q, v_d;

  logic [WORD_WIDTH-1:0]   head_word;
  logic [WORD_WIDTH-1:0]   head_shift;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [IW-1:0]           inflight;
  logic                    in_run;
  logic                    rd_en;
  logic                    valid;
  logic                    xfer;
  logic                    at_eol;
  logic                    at_last;
  logic                    pop;
  logic                    push;

  grey_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_WIDTH)
  ) u_fifo (
    .clk   (clk_pixel_in),
    .rst_n (rst_n_in),
    .push  (push),
    .wdata (rd_data_in),
    .pop   (pop),
    .rdata (head_word),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + IW'(vld_sr_q[i]);
    end

    in_run  = (state_q == RUN);
    valid   = in_run && !fifo_empty;
    xfer    = valid && pixel_ready_in;
    at_eol  = (h_q == H_LAST);
    at_last = at_eol && (v_q == V_LAST);
    // The final word may carry unused lanes; it is popped at the last pixel.
    pop     = xfer && ((lane_q == LANE_LAST) || at_last);
    // Oldest stage of the return pipeline lines up with rd_data_in.
    push    = vld_sr_q[READ_LATENCY-1];
    rd_en   = in_run && (issued_q < WORDS_A) &&
              ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

    state_d  = state_q;
    issued_d = issued_q;
    lane_d   = lane_q;
    h_d      = h_q;
    v_d      = v_q;
    vld_sr_d = (vld_sr_q << 1) | READ_LATENCY'(rd_en);

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d  = RUN;
          issued_d = '0;
          lane_d   = '0;
          h_d      = '0;
          v_d      = '0;
        end
      end
      RUN: begin
        if (rd_en) begin
          issued_d = issued_q + ADDR_WIDTH'(1);
        end
        if (xfer) begin
          lane_d = pop ? 3'd0 : lane_q + 3'd1;
          if (at_eol) begin
            h_d = '0;
            v_d = at_last ? 10'd0 : v_q + 10'd1;
          end else begin
            h_d = h_q + 11'd1;
          end
          if (at_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        issued_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      issued_q <= '0;
      vld_sr_q <= '0;
      lane_q   <= '0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      vld_sr_q <= vld_sr_d;
      lane_q   <= lane_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  // Bring the current lane into the top byte of the word.
  assign head_shift = head_word << {lane_q, 3'b000};

  assign addr_out        = issued_q;
  assign rd_en_out       = rd_en;
  assign pixel_valid_out = valid;
  assign pixel_out       = valid ? head_shift[WORD_WIDTH-1 -: 8] : 8'd0;
  assign h_out           = h_q;
  assign v_out           = v_q;
  assign sof_out         = valid && (h_q == 11'd0) && (v_q == 10'd0);
  assign eol_out         = valid && at_eol;
  assign eof_out         = valid && at_last;
  assign busy_out        = in_run;
  assign done_out        = (state_q == DONE);
  assign state_dbg_out   = state_q;

endmodule

// File: tb/tb_grey_frame_reader.sv
// Bench for grey_frame_reader. A 320x24 instance exercises line wrap,
// backpressure, start filtering and mid-frame reset; an 8x2 instance covers
// a frame whose last word is only partly used.
module tb_grey_frame_reader;
  import grey_fb_pkg::*;

  localparam int H    = 320;
  localparam int V    = 24;
  localparam int AW   = 17;
  localparam int RL   = 2;
  localparam int NPIX = H * V;
  localparam int NW   = (NPIX + 5) / 6;
  localparam int HS   = 8;
  localparam int VS   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          start, rd_en, pv, ready = 1'b1, sof, eol, eof, busy, done;
  logic [AW-1:0] addr, b_addr1;
  logic [47:0]   rd_data;
  logic [7:0]    pix;
  logic [10:0]   h;
  logic [9:0]    v;
  reader_state_t st;

  logic          start_s, rd_en_s, pv_s, ready_s, sof_s, eol_s, eof_s, busy_s, done_s;
  logic [AW-1:0] addr_s, bs_addr1;
  logic [47:0]   rd_data_s;
  logic [7:0]    pix_s;
  logic [10:0]   h_s;
  logic [9:0]    v_s;
  reader_state_t st_s;

  grey_frame_reader #(.H_PIXELS(H), .V_LINES(V), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .start_in(start),
    .addr_out(addr), .rd_en_out(rd_en), .rd_data_in(rd_data),
    .pixel_out(pix), .h_out(h), .v_out(v),
    .pixel_valid_out(pv), .pixel_ready_in(ready),
    .sof_out(sof), .eol_out(eol), .eof_out(eof),
    .busy_out(busy), .done_out(done), .state_dbg_out(st)
  );

  grey_frame_reader #(.H_PIXELS(HS), .V_LINES(VS), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut_s (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .start_in(start_s),
    .addr_out(addr_s), .rd_en_out(rd_en_s), .rd_data_in(rd_data_s),
    .pixel_out(pix_s), .h_out(h_s), .v_out(v_s),
    .pixel_valid_out(pv_s), .pixel_ready_in(ready_s),
    .sof_out(sof_s), .eol_out(eol_s), .eof_out(eof_s),
    .busy_out(busy_s), .done_out(done_s), .state_dbg_out(st_s)
  );

  // ---------------- BRAM model: word w holds bytes 6w..6w+5 ----------------
  function automatic logic [47:0] bram_word(input logic [AW-1:0] a);
    logic [47:0] w;
    int base;
    base = 6 * int'(a);
    w = '0;
    for (int k = 0; k < 6; k++) w[47-8*k -: 8] = 8'((base + k) % 256);
    return w;
  endfunction

  // Two-stage read pipeline: address captured, then data registered.
  always @(posedge clk) begin
    b_addr1   <= addr;
    rd_data   <= bram_word(b_addr1);
    bs_addr1  <= addr_s;
    rd_data_s <= bram_word(bs_addr1);
  end

  // ---------------- check bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- scoreboard / model ----------------
  logic [7:0] exp_q[$];
  int  exp_idx = 0;
  int  rd_cnt = 0;
  int  start_cyc = 0;
  int  done_cnt = 0;
  int  eof_cnt = 0;
  int  p;
  bit  m_busy = 0;
  bit  m_done_due = 0;
  bit  first_pending = 0;
  bit  eof_xfer;
  bit  done_now;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", pv, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_addr", addr, 0);
      chk("rst_pixel", pix, 0);
      chk("rst_h", h, 0);
      chk("rst_v", v, 0);
      chk("rst_markers", {sof, eol, eof}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      exp_q.delete();
      exp_idx = 0;
      rd_cnt = 0;
      m_busy = 0;
      m_done_due = 0;
      first_pending = 0;
    end else begin
      eof_xfer = 0;
      done_now = m_done_due;
      chk("busy", busy, m_busy);
      chk("done", done, m_done_due);
      if (done) begin
        done_cnt++;
        chk("reads_per_frame", rd_cnt, NW);
      end
      if (rd_en) begin
        chk("rd_while_busy", m_busy, 1);
        chk("rd_in_range", rd_cnt < NW, 1);
        chk("rd_addr", addr, rd_cnt);
        rd_cnt++;
      end
      if (pv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_pixel: got pixel %0d at (%0d,%0d) expected none at t=%0t", pix, h, v, $time);
        end else begin
          p = exp_idx;
          if (first_pending) begin
            chk("first_latency", cyc - start_cyc, 4);
            first_pending = 0;
          end
          chk("pixel", pix, exp_q[0]);
          chk("h", h, p % H);
          chk("v", v, p / H);
          chk("sof", sof, p == 0);
          chk("eol", eol, (p % H) == H - 1);
          chk("eof", eof, p == NPIX - 1);
          // Hand-computed anchors: word 53 spans the first line end.
          case (p)
            318: begin chk("pin318_h", h, 318); chk("pin318_pix", pix, 62); chk("pin318_eol", eol, 0); end
            319: begin chk("pin319_h", h, 319); chk("pin319_pix", pix, 63); chk("pin319_eol", eol, 1); end
            320: begin chk("pin320_hv", {h, v}, {11'd0, 10'd1}); chk("pin320_pix", pix, 64); end
            321: begin chk("pin321_hv", {h, v}, {11'd1, 10'd1}); chk("pin321_pix", pix, 65); end
            7679: begin chk("pin_last_hv", {h, v}, {11'd319, 10'd23}); chk("pin_last_pix", pix, 255); end
            default: ;
          endcase
          if (ready) begin
            void'(exp_q.pop_front());
            exp_idx++;
            if (p == NPIX - 1) eof_xfer = 1;
          end
        end
      end
      // State the outputs must reflect after the coming edge.
      m_done_due = 0;
      if (eof_xfer) begin
        m_busy = 0;
        m_done_due = 1;
        eof_cnt++;
      end else if (!m_busy && !done_now && start) begin
        m_busy = 1;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(8'(i % 256));
        exp_idx = 0;
        rd_cnt = 0;
        first_pending = 1;
        start_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, done_cnt - d0, 1);
    #1;
  endtask

  task automatic small_frame();
    int idx, dn, rds;
    idx = 0; dn = 0; rds = 0;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (rd_en_s) begin
        chk("s_addr", addr_s, rds);
        rds++;
      end
      if (done_s) dn++;
      if (pv_s) begin
        chk("s_pixel", pix_s, idx % 256);
        chk("s_h", h_s, idx % HS);
        chk("s_v", v_s, idx / HS);
        chk("s_sof", sof_s, idx == 0);
        chk("s_eol", eol_s, (idx % HS) == HS - 1);
        chk("s_eof", eof_s, idx == HS * VS - 1);
        if (idx == 15) begin
          chk("s_eof_h", h_s, 7);
          chk("s_eof_v", v_s, 1);
          chk("s_eof_pix", pix_s, 15);
        end
        idx++;
      end
    end
    chk("s_pixel_count", idx, 16);
    chk("s_read_count", rds, 3);
    chk("s_done_count", dn, 1);
    chk("s_busy_after", busy_s, 0);
  endtask

  // ---------------- main sequence ----------------
  int d0, e0, n;
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    ready_s = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame, ready held high.
    ready_mode = 0;
    run_frame();
    wait_done("frame_ready_high", NPIX + 200);
    repeat (5) @(posedge clk);
    #1;

    // Full frame, random backpressure.
    ready_mode = 1;
    run_frame();
    wait_done("frame_random_ready", 3 * NPIX);
    ready_mode = 0;
    repeat (5) @(posedge clk);
    #1;

    // start pulses in RUN and in the DONE cycle are ignored.
    d0 = done_cnt;
    e0 = eof_cnt;
    run_frame();
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (eof_cnt == e0 && n < NPIX + 200) begin
      @(posedge clk);
      n++;
    end
    chk("eof_seen", eof_cnt - e0, 1);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    chk("one_done_only", done_cnt - d0, 1);
    chk("idle_after_frame", busy, 0);
    #1;

    // Reset in the middle of a frame, then a clean restart.
    run_frame();
    n = 0;
    while (exp_idx < 1000 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("reached_mid_frame", exp_idx >= 1000, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_now_valid", pv, 0);
    chk("rst_now_rd_en", rd_en, 0);
    chk("rst_now_addr", addr, 0);
    chk("rst_now_hv", {h, v}, 0);
    chk("rst_now_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame();
    wait_done("frame_after_reset", NPIX + 200);

    // Small frame with a partly used last word.
    small_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish expected finish by t=%0t", $time);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
